// File: rtl/sram_fifo_ctrl.sv
// Ready/valid FIFO wrapped around a 1R1W SRAM macro with registered read.
// A 2-entry output buffer absorbs the macro read latency so the FIFO streams at one word per cycle.
module sram_fifo_ctrl #(
    parameter int DEPTH = 512,
    parameter int AW    = 9,
    parameter int DW    = 64,
    parameter int MW    = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enq_valid,
    output logic          enq_ready,
    input  logic [DW-1:0] enq_bits,
    output logic          deq_valid,
    input  logic          deq_ready,
    output logic [DW-1:0] deq_bits,
    output logic [AW+1:0] count,
    output logic [AW-1:0] W0_addr,
    output logic          W0_en,
    output logic [DW-1:0] W0_data,
    output logic [MW-1:0] W0_mask,
    output logic [AW-1:0] R0_addr,
    output logic          R0_en,
    input  logic [DW-1:0] R0_data
);

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   sram_cnt;
    logic          inflight;
    logic [DW-1:0] obuf [2];
    logic [1:0]    obuf_cnt;
    logic          head;
    logic          tail;
    logic          enq_fire;
    logic          deq_fire;
    logic          rd_issue;
    logic [2:0]    pending;

    assign enq_ready = (sram_cnt != DEPTH_C);
    assign enq_fire  = enq_valid & enq_ready & ~reset;
    assign deq_valid = (obuf_cnt != 2'd0);
    assign deq_fire  = deq_valid & deq_ready;
    assign deq_bits  = obuf[head];

    // Issue a read only if the buffer still has room once this cycle's dequeue
    // and any returning read are accounted for.
    assign pending  = {1'b0, obuf_cnt} + {2'b00, inflight};
    assign rd_issue = ~reset & (sram_cnt != '0) & (pending < (3'd2 + {2'b00, deq_fire}));

    // A return can only arrive with obuf_cnt <= 1, so the tail slot is head + obuf_cnt[0].
    assign tail = head ^ obuf_cnt[0];

    assign count = (AW+2)'(sram_cnt) + (AW+2)'(inflight) + (AW+2)'(obuf_cnt);

    assign W0_addr = wptr;
    assign W0_en   = enq_fire;
    assign W0_data = enq_bits;
    assign W0_mask = '1;
    assign R0_addr = rptr;
    assign R0_en   = rd_issue;

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            sram_cnt <= '0;
            inflight <= 1'b0;
            obuf_cnt <= 2'd0;
            head     <= 1'b0;
        end else begin
            if (enq_fire) begin
                wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
            end
            if (rd_issue) begin
                rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
            end
            if (enq_fire && !rd_issue) begin
                sram_cnt <= sram_cnt + 1'b1;
            end else if (!enq_fire && rd_issue) begin
                sram_cnt <= sram_cnt - 1'b1;
            end
            inflight <= rd_issue;
            obuf_cnt <= obuf_cnt + {1'b0, inflight} - {1'b0, deq_fire};
            if (deq_fire) begin
                head <= ~head;
            end
        end
    end

    // Data slots carry no reset; occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (!reset && inflight) begin
            obuf[tail] <= R0_data;
        end
    end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Scoreboard bench for sram_fifo_ctrl: default build plus a DEPTH=5 build sharing the same stimulus.
// Behavioural SRAM macros with registered read sit beside each instance.
module tb_sram_fifo_ctrl;

    logic        clock;
    logic        reset;
    logic        enq_valid;
    logic [63:0] enq_bits;
    logic        deq_ready;

    logic        enq_ready, deq_valid, W0_en, R0_en;
    logic [63:0] deq_bits, W0_data, R0_data;
    logic [10:0] count;
    logic [8:0]  W0_addr, R0_addr;
    logic [7:0]  W0_mask;

    logic        s_enq_ready, s_deq_valid, s_W0_en, s_R0_en;
    logic [63:0] s_deq_bits, s_W0_data, s_R0_data;
    logic [4:0]  s_count;
    logic [2:0]  s_W0_addr, s_R0_addr;
    logic [7:0]  s_W0_mask;

    sram_fifo_ctrl dut (
        .clock(clock), .reset(reset),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_bits(enq_bits),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_bits(deq_bits),
        .count(count),
        .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data), .W0_mask(W0_mask),
        .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data)
    );

    sram_fifo_ctrl #(.DEPTH(5), .AW(3), .DW(64), .MW(8)) dut6 (
        .clock(clock), .reset(reset),
        .enq_valid(enq_valid), .enq_ready(s_enq_ready), .enq_bits(enq_bits),
        .deq_valid(s_deq_valid), .deq_ready(deq_ready), .deq_bits(s_deq_bits),
        .count(s_count),
        .W0_addr(s_W0_addr), .W0_en(s_W0_en), .W0_data(s_W0_data), .W0_mask(s_W0_mask),
        .R0_addr(s_R0_addr), .R0_en(s_R0_en), .R0_data(s_R0_data)
    );

    logic [63:0] mem  [0:511];
    logic [63:0] mem6 [0:7];

    always @(posedge clock) begin
        if (W0_en) mem[W0_addr] <= W0_data;
        if (R0_en) R0_data <= mem[R0_addr];
        if (s_W0_en) mem6[s_W0_addr] <= s_W0_data;
        if (s_R0_en) s_R0_data <= mem6[s_R0_addr];
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard for the default build
    logic [63:0] q[$];
    int          occ = 0;
    int          ndeq = 0;
    logic        held_v = 1'b0;
    logic [63:0] held_bits;

    always @(negedge clock) begin
        if (reset) begin
            q.delete();
            occ    = 0;
            held_v = 1'b0;
        end else begin
            chk("count_vs_model", 64'(count), 64'(occ));
            chk("enq_ready_vs_full", 64'(enq_ready), 64'(occ != 514));
            if (held_v) begin
                chk("stall_valid_hold", 64'(deq_valid), 64'd1);
                chk("stall_bits_hold", deq_bits, held_bits);
            end
            held_v    = deq_valid && !deq_ready;
            held_bits = deq_bits;
            if (deq_valid && deq_ready) begin
                if (q.size() == 0) begin
                    chk("deq_with_empty_scoreboard", 64'(q.size()), 64'd1);
                end else begin
                    chk("deq_bits", deq_bits, q.pop_front());
                end
                occ--;
                ndeq++;
            end
            if (enq_valid && enq_ready) begin
                q.push_back(enq_bits);
                occ++;
            end
        end
    end

    // Scoreboard for the DEPTH=5 build
    logic [63:0] q6[$];
    int          occ6 = 0;
    logic        held6_v = 1'b0;
    logic [63:0] held6_bits;

    always @(negedge clock) begin
        if (reset) begin
            q6.delete();
            occ6    = 0;
            held6_v = 1'b0;
        end else begin
            chk("d5_count_vs_model", 64'(s_count), 64'(occ6));
            chk("d5_enq_ready_vs_full", 64'(s_enq_ready), 64'(occ6 != 7));
            if (held6_v) begin
                chk("d5_stall_bits_hold", s_deq_bits, held6_bits);
            end
            held6_v    = s_deq_valid && !deq_ready;
            held6_bits = s_deq_bits;
            if (s_deq_valid && deq_ready) begin
                if (q6.size() == 0) begin
                    chk("d5_deq_with_empty_scoreboard", 64'(q6.size()), 64'd1);
                end else begin
                    chk("d5_deq_bits", s_deq_bits, q6.pop_front());
                end
                occ6--;
            end
            if (enq_valid && s_enq_ready) begin
                q6.push_back(enq_bits);
                occ6++;
            end
        end
    end

    logic        use6 = 1'b0;
    logic        fired;
    logic [63:0] next_data;

    task automatic half();
        @(negedge clock);
        fired = use6 ? (enq_valid & s_enq_ready) : (enq_valid & enq_ready);
    endtask

    task automatic fin();
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        logic ok;
        ok        = 1'b0;
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        for (int i = 0; i < 1200 && !ok; i++) begin
            half();
            ok = use6 ? (s_count == 5'd0) : (count == 11'd0);
            fin();
        end
        chk("drain_completes", 64'(ok), 64'd1);
    endtask

    initial begin
        int acc;
        int base;
        int bubbles;
        int badcnt;
        logic seen;

        reset     = 1'b1;
        enq_valid = 1'b0;
        enq_bits  = '0;
        deq_ready = 1'b0;
        next_data = '0;
        fin();
        fin();
        reset = 1'b0;

        // reset state
        half();
        chk("rst_deq_valid", 64'(deq_valid), 64'd0);
        chk("rst_enq_ready", 64'(enq_ready), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        chk("w0_mask", 64'(W0_mask), 64'hFF);
        fin();

        // 1: single-entry latency
        enq_valid = 1'b1;
        enq_bits  = 64'hDEADBEEF_00000001;
        deq_ready = 1'b1;
        half();
        chk("t1_c0_w0_en", 64'(W0_en), 64'd1);
        chk("t1_c0_r0_en", 64'(R0_en), 64'd0);
        fin();
        enq_valid = 1'b0;
        half();
        chk("t1_c1_r0_en", 64'(R0_en), 64'd1);
        chk("t1_c1_deq_valid", 64'(deq_valid), 64'd0);
        fin();
        half();
        chk("t1_c2_deq_valid", 64'(deq_valid), 64'd0);
        fin();
        half();
        chk("t1_c3_deq_valid", 64'(deq_valid), 64'd1);
        chk("t1_c3_deq_bits", deq_bits, 64'hDEADBEEF_00000001);
        fin();
        half();
        chk("t1_c4_count", 64'(count), 64'd0);
        fin();

        // 2: fill to DEPTH+2 without draining, then drain in order
        deq_ready = 1'b0;
        next_data = 64'd0;
        acc       = 0;
        seen      = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            enq_valid = 1'b1;
            enq_bits  = next_data;
            half();
            if (fired) begin
                acc++;
                next_data++;
            end
            seen = !enq_ready;
            fin();
        end
        chk("t2_accepts", 64'(acc), 64'd514);
        chk("t2_count_full", 64'(count), 64'd514);
        for (int i = 0; i < 4; i++) begin
            enq_valid = 1'b1;
            enq_bits  = 64'hBAD;
            half();
            chk("t2_w0_en_while_full", 64'(W0_en), 64'd0);
            fin();
        end
        base = ndeq;
        drain();
        chk("t2_drained_entries", 64'(ndeq - base), 64'd514);

        // 3: continuous streaming across pointer wrap
        next_data = 64'h1000;
        bubbles   = 0;
        badcnt    = 0;
        acc       = 0;
        for (int i = 0; i < 2000; i++) begin
            enq_valid = 1'b1;
            enq_bits  = next_data;
            deq_ready = 1'b1;
            half();
            if (i >= 3 && !deq_valid) bubbles++;
            if (i >= 3 && count != 11'd3) badcnt++;
            if (fired) begin
                acc++;
                next_data++;
            end
            fin();
        end
        chk("t3_accepts", 64'(acc), 64'd2000);
        chk("t3_bubbles", 64'(bubbles), 64'd0);
        chk("t3_count_not_3", 64'(badcnt), 64'd0);
        drain();

        // 4: random producer and 30% consumer backpressure
        next_data = 64'h5000_0000;
        acc       = 0;
        base      = ndeq;
        for (int i = 0; i < 1500; i++) begin
            enq_valid = ($urandom_range(99, 0) < 70);
            enq_bits  = next_data;
            deq_ready = ($urandom_range(99, 0) >= 30);
            half();
            if (fired) begin
                acc++;
                next_data++;
            end
            fin();
        end
        drain();
        chk("t4_no_loss", 64'(ndeq - base), 64'(acc));
        chk("t4_sb_empty", 64'(q.size()), 64'd0);

        // 5: reset with a read in flight and a partly filled buffer
        deq_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            enq_valid = 1'b1;
            enq_bits  = 64'hA0 + 64'(i);
            half();
            fin();
        end
        reset     = 1'b1;
        enq_valid = 1'b1;
        enq_bits  = 64'hBAD;
        half();
        chk("t5_w0_en_in_reset", 64'(W0_en), 64'd0);
        chk("t5_r0_en_in_reset", 64'(R0_en), 64'd0);
        fin();
        reset     = 1'b0;
        enq_valid = 1'b1;
        enq_bits  = 64'h5;
        deq_ready = 1'b1;
        half();
        chk("t5_deq_valid_after_rst", 64'(deq_valid), 64'd0);
        chk("t5_count_after_rst", 64'(count), 64'd0);
        chk("t5_enq_ready_after_rst", 64'(enq_ready), 64'd1);
        fin();
        enq_valid = 1'b0;
        seen      = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            half();
            if (deq_valid) begin
                seen = 1'b1;
                chk("t5_first_after_rst", deq_bits, 64'h5);
            end
            fin();
        end
        chk("t5_deq_seen", 64'(seen), 64'd1);
        drain();

        // 6: DEPTH=5 build, fill, release one slot, interleave across wrap
        use6      = 1'b1;
        reset     = 1'b1;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        fin();
        reset     = 1'b0;
        next_data = 64'h600;
        acc       = 0;
        seen      = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            enq_valid = 1'b1;
            enq_bits  = next_data;
            half();
            if (fired) begin
                acc++;
                next_data++;
            end
            seen = !s_enq_ready;
            fin();
        end
        chk("t6_accepts", 64'(acc), 64'd7);
        chk("t6_count_full", 64'(s_count), 64'd7);
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        half();
        chk("t6_head_valid", 64'(s_deq_valid), 64'd1);
        chk("t6_head_bits", s_deq_bits, 64'h600);
        fin();
        deq_ready = 1'b0;
        half();
        chk("t6_ready_after_release", 64'(s_enq_ready), 64'd1);
        fin();
        for (int i = 0; i < 40; i++) begin
            enq_valid = 1'b1;
            enq_bits  = next_data;
            deq_ready = (i % 2 == 1);
            half();
            if (fired) next_data++;
            fin();
        end
        drain();
        chk("t6_sb_empty", 64'(q6.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
